// File: rtl/ps2_key_ctrl.sv
`timescale 1ns/1ps
// ps2_key_ctrl: PS/2 keyboard frame receiver, scancode FIFO and make-code
// decoder that writes make codes to a cursor-addressed character RAM.
module ps2_key_ctrl #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] WRAP_ADDR  = 8'hFE
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       stall,
  output logic       we,
  output logic [7:0] inaddr,
  output logic [7:0] din,
  output logic       ext,
  output logic [7:0] err_cnt,
  output logic       overflow
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    EMIT    = 3'd4
  } state_t;

  // Error counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Cursor advance; WRAP_ADDR is the last address before returning to zero.
  function automatic logic [7:0] next_cursor(input logic [7:0] v);
    return (v == WRAP_ADDR) ? 8'h00 : v + 8'd1;
  endfunction

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [10:0]   frame;
  logic          check;
  logic          frame_ok;
  logic          shift_en;
  logic          push_pend;
  logic [7:0]    push_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic [7:0]    head;

  state_t        state;
  state_t        next_state;
  logic          pop;
  logic          load;
  logic          set_ext;
  logic          clr_ext;
  logic          ext_flag;

  // Falling edge taken from the two oldest clock stages; the extra stage
  // keeps the edge decision away from the metastable first flop.
  assign fall     = (clk_sync[2:1] == 2'b10);
  assign check    = (bit_cnt == 4'd11);
  assign shift_en = fall && !check;
  assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

  // Input synchronisers, idle-high after reset like the PS/2 lines.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Frame data: bits arrive LSB first, so the start bit settles in frame[0].
  always_ff @(posedge clk) begin
    if (shift_en) frame <= {data_sync[1], frame[10:1]};
    if (check && frame_ok) push_byte <= frame[8:1];
  end

  // Bit counting, frame acceptance and error accounting.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= 4'd0;
      push_pend <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      push_pend <= check && frame_ok;
      if (check) bit_cnt <= 4'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (check && !frame_ok) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign do_push = push_pend && !full;
  assign head    = mem[rd_ptr[AW-1:0]];

  // FIFO storage; a push that meets a full FIFO is simply not written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_pend && full) overflow <= 1'b1;
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else state <= next_state;
  end

  // Decoder next state; stall only holds off the first pop of a sequence.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    set_ext    = 1'b0;
    clr_ext    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !stall) begin
          pop = 1'b1;
          if (head == CODE_EXT) begin
            next_state = EXT;
            set_ext    = 1'b1;
          end else if (head == CODE_BRK) begin
            next_state = BRK;
          end else begin
            next_state = EMIT;
            load       = 1'b1;
          end
        end
      end
      EXT: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == CODE_BRK) begin
            next_state = EXT_BRK;
          end else begin
            next_state = EMIT;
            load       = 1'b1;
          end
        end
      end
      BRK: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      EXT_BRK: begin
        if (!empty) begin
          pop        = 1'b1;
          clr_ext    = 1'b1;
          next_state = IDLE;
        end
      end
      EMIT: begin
        clr_ext    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write data, extended flag and cursor; din/ext hold between writes.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_flag <= 1'b0;
      din      <= 8'h00;
      ext      <= 1'b0;
      inaddr   <= 8'h00;
    end else begin
      if (set_ext) ext_flag <= 1'b1;
      else if (clr_ext) ext_flag <= 1'b0;
      if (load) begin
        din <= head;
        ext <= ext_flag;
      end
      if (state == EMIT) inaddr <= next_cursor(inaddr);
    end
  end

  assign we = (state == EMIT);

endmodule

// File: tb/tb_ps2_key_ctrl.sv
`timescale 1ns/1ps
// tb_ps2_key_ctrl: table vectors, hand sequences and randomized frames
// against a queue-based reference model of the keyboard controller.
module tb_ps2_key_ctrl;

  localparam int DEPTH = 8;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       stall;
  logic       we;
  logic [7:0] inaddr;
  logic [7:0] din;
  logic       ext;
  logic [7:0] err_cnt;
  logic       overflow;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .WRAP_ADDR(8'hFE)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .stall    (stall),
    .we       (we),
    .inaddr   (inaddr),
    .din      (din),
    .ext      (ext),
    .err_cnt  (err_cnt),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int we_count = 0;

  // Reference model state: bytes accepted but not yet decoded, expected
  // writes as {din, ext, addr}, and the decoder's prefix/break memory.
  logic [7:0]  m_pend [$];
  logic [16:0] exp_q [$];
  int          m_err;
  logic        m_ovf;
  int          m_writes;
  logic        m_ext;
  logic        m_skip;

  typedef struct {
    logic [7:0] code;
    logic       bad;
    int         exp_we;
    logic [7:0] exp_din;
    logic       exp_ext;
    logic [7:0] exp_addr;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    exp_q.delete();
    m_err    = 0;
    m_ovf    = 1'b0;
    m_writes = 0;
    m_ext    = 1'b0;
    m_skip   = 1'b0;
  endtask

  task automatic model_decode(input logic [7:0] b);
    if (m_skip) begin
      m_skip = 1'b0;
      m_ext  = 1'b0;
    end else if (b == 8'hE0 && !m_ext) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_skip = 1'b1;
    end else begin
      exp_q.push_back({b, m_ext, 8'(m_writes % 255)});
      m_writes++;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_drain();
    while (m_pend.size() > 0) model_decode(m_pend.pop_front());
  endtask

  task automatic model_frame(input logic [7:0] code, input logic bad);
    if (bad) begin
      if (m_err < 255) m_err++;
    end else if (m_pend.size() >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      m_pend.push_back(code);
    end
    if (!stall) model_drain();
  endtask

  // Every write strobe is matched in order against the model's expectations.
  always @(negedge clk) begin
    if (clrn && we) begin
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we din=%0h ext=%0b addr=%0h required=no write", din, ext, inaddr);
      end else begin
        chk("write_din_ext_addr", {15'b0, din, ext, inaddr}, {15'b0, exp_q.pop_front()});
      end
    end
  end

  // Drives one frame bit by bit; lat checks the make-code strobe timing.
  task automatic send_frame(input logic [7:0] code, input logic bad, input logic lat);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad, code, 1'b0};
    model_frame(code, bad);
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      @(negedge clk);
      ps2_clk = 1'b0;
      if (lat && i == 10) begin
        repeat (5) @(negedge clk);
        chk("latency_we_low", {31'b0, we}, 32'd0);
        @(negedge clk);
        chk("latency_we_high", {31'b0, we}, 32'd1);
      end else begin
        repeat (2) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] code, input int n);
    logic [10:0] f;
    f = {1'b1, ~^code, code, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic check);
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    stall    = 1'b0;
    repeat (3) @(negedge clk);
    if (check) begin
      chk("rst_we", {31'b0, we}, 32'd0);
      chk("rst_din", {24'b0, din}, 32'h00);
      chk("rst_ext", {31'b0, ext}, 32'd0);
      chk("rst_inaddr", {24'b0, inaddr}, 32'h00);
      chk("rst_err_cnt", {24'b0, err_cnt}, 32'h00);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
    end
    clrn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int burst;
    logic [7:0] code;
    logic bad;

    vecs[0]  = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 8'h01, 8'h00};
    vecs[1]  = '{8'hF0, 1'b0, 1, 8'h1C, 1'b0, 8'h01, 8'h00};
    vecs[2]  = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 8'h01, 8'h00};
    vecs[3]  = '{8'hE0, 1'b0, 1, 8'h1C, 1'b0, 8'h01, 8'h00};
    vecs[4]  = '{8'h75, 1'b0, 2, 8'h75, 1'b1, 8'h02, 8'h00};
    vecs[5]  = '{8'hE0, 1'b0, 2, 8'h75, 1'b1, 8'h02, 8'h00};
    vecs[6]  = '{8'hF0, 1'b0, 2, 8'h75, 1'b1, 8'h02, 8'h00};
    vecs[7]  = '{8'h75, 1'b0, 2, 8'h75, 1'b1, 8'h02, 8'h00};
    vecs[8]  = '{8'h1C, 1'b1, 2, 8'h75, 1'b1, 8'h02, 8'h01};
    vecs[9]  = '{8'h32, 1'b0, 3, 8'h32, 1'b0, 8'h03, 8'h01};
    vecs[10] = '{8'h32, 1'b0, 4, 8'h32, 1'b0, 8'h04, 8'h01};

    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    stall = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(1'b1);

    // Table vectors: make, break, extended and bad-parity frames.
    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].code, vecs[i].bad, 1'b0);
      chk($sformatf("vec%0d_we_count", i), we_count, vecs[i].exp_we);
      chk($sformatf("vec%0d_din", i), {24'b0, din}, {24'b0, vecs[i].exp_din});
      chk($sformatf("vec%0d_ext", i), {31'b0, ext}, {31'b0, vecs[i].exp_ext});
      chk($sformatf("vec%0d_inaddr", i), {24'b0, inaddr}, {24'b0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_err_cnt", i), {24'b0, err_cnt}, {24'b0, vecs[i].exp_err});
    end

    // Make-code latency from the frame check.
    send_frame(8'h29, 1'b0, 1'b1);
    chk("lat_inaddr", {24'b0, inaddr}, 32'h05);

    // Reset in the middle of a prefixed frame discards both.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bits(8'h44, 5);
    do_reset(1'b1);
    base = we_count;
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("post_rst_we_count", we_count, base + 1);
    chk("post_rst_ext", {31'b0, ext}, 32'd0);
    chk("post_rst_inaddr", {24'b0, inaddr}, 32'h01);

    // Stalled decoder: nine frames overflow an eight-entry FIFO.
    do_reset(1'b0);
    base = we_count;
    stall = 1'b1;
    for (int k = 0; k < 9; k++) send_frame(8'h10 + 8'(k), 1'b0, 1'b0);
    chk("stall_no_we", we_count, base);
    chk("stall_overflow", {31'b0, overflow}, 32'd1);
    model_drain();
    stall = 1'b0;
    repeat (40) @(negedge clk);
    chk("stall_release_we_count", we_count, base + 8);
    chk("stall_pending", exp_q.size(), 32'd0);

    // Randomized frames with short stall bursts.
    do_reset(1'b0);
    burst = 0;
    for (int i = 0; i < 150; i++) begin
      if (burst == 0 && !m_ext && !m_skip && $urandom_range(0, 9) == 0) begin
        stall = 1'b1;
        burst = $urandom_range(1, 4);
      end
      case ($urandom_range(0, 9))
        0, 1:    code = 8'hE0;
        2, 3:    code = 8'hF0;
        default: code = 8'($urandom_range(1, 255));
      endcase
      bad = ($urandom_range(0, 9) == 0);
      send_frame(code, bad, 1'b0);
      if (burst > 0) begin
        burst--;
        if (burst == 0) begin
          model_drain();
          stall = 1'b0;
          repeat (20) @(negedge clk);
        end
      end
    end
    if (stall) begin
      model_drain();
      stall = 1'b0;
      repeat (20) @(negedge clk);
    end
    chk("rand_pending", exp_q.size(), 32'd0);
    chk("rand_err_cnt", {24'b0, err_cnt}, m_err);
    chk("rand_overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("rand_inaddr", {24'b0, inaddr}, m_writes % 255);

    // Cursor wrap after FE.
    do_reset(1'b0);
    for (int k = 0; k < 254; k++) send_frame(8'h1C, 1'b0, 1'b0);
    chk("wrap_inaddr_fe", {24'b0, inaddr}, 32'hFE);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("wrap_inaddr_00", {24'b0, inaddr}, 32'h00);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("wrap_inaddr_01", {24'b0, inaddr}, 32'h01);
    chk("wrap_pending", exp_q.size(), 32'd0);

    // Error counter saturation.
    do_reset(1'b0);
    base = we_count;
    for (int k = 0; k < 256; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    chk("sat_err_cnt", {24'b0, err_cnt}, 32'hFF);
    chk("sat_no_we", we_count, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
